// File: rtl/i2s_tx_ctrl_pkg.sv
// Shared definitions for the I2S transmit path: default geometry,
// channel encoding of the word-select line and frame-load classification.
package i2s_tx_ctrl_pkg;

    // Default sample word length in bits.
    localparam int DWL_DEFAULT      = 12;
    // Default number of BCLK periods per channel slot.
    localparam int SLOT_DEFAULT     = 16;
    // Default number of system clocks per BCLK period.
    localparam int BCLK_DIV_DEFAULT = 4;

    // Word-select encoding: the left channel is sent while LRCK is low.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    // What happens to the shifter at a frame boundary.
    typedef enum logic [1:0] {
        LOAD_NONE     = 2'd0,
        LOAD_SAMPLE   = 2'd1,
        LOAD_UNDERRUN = 2'd2
    } load_e;

endpackage

// File: rtl/i2s_tx_ctrl_bclk_gen.sv
// Bit-clock generator: divides CLK by BCLK_DIV, drives a registered BCLK
// that rises mid-period and falls on TICK, the last CLK of each BCLK period.
module i2s_bclk_gen
    import i2s_tx_ctrl_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    output logic BCLK,
    output logic TICK
);

    localparam int CW = $clog2(BCLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] DIV_MID  = CW'(BCLK_DIV / 2 - 1);

    logic [CW-1:0] div_cnt;

    assign TICK = EN && (div_cnt == DIV_LAST);

    // Divider counter: runs 0..BCLK_DIV-1 while enabled, parks at 0 when idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
        end else if (!EN || TICK) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // BCLK flop: high for the second half of each period, low on the tick edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BCLK <= 1'b0;
        end else if (!EN || TICK) begin
            BCLK <= 1'b0;
        end else if (div_cnt == DIV_MID) begin
            BCLK <= 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: takes left/right sample pairs over VLD/RDY into a
// one-deep holding register, loads a 2*SLOT bit frame at each frame boundary
// and shifts it out MSB first, one BCLK after each LRCK transition.
module i2s_tx_ctrl
    import i2s_tx_ctrl_pkg::*;
#(
    parameter int DWL      = DWL_DEFAULT,
    parameter int SLOT     = SLOT_DEFAULT,
    parameter int BCLK_DIV = BCLK_DIV_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic signed [DWL-1:0] DIN_L,
    input  logic signed [DWL-1:0] DIN_R,
    input  logic                  DIN_VLD,
    output logic                  DIN_RDY,
    output logic                  BCLK,
    output logic                  LRCK,
    output logic                  SDATA,
    output logic                  FRAME_STB,
    output logic                  UNDERRUN
);

    localparam int FW = 2 * SLOT;
    localparam int BW = $clog2(FW);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FW - 1);
    localparam logic [BW-1:0] SLOT_START = BW'(SLOT);

    logic           tick;
    logic [BW-1:0]  bit_cnt;
    logic [BW-1:0]  bit_cnt_next;
    logic [FW-1:0]  fr;
    logic [FW-1:0]  frame_word;
    logic [SLOT-1:0] slot_l;
    logic [SLOT-1:0] slot_r;
    logic           hold_full;
    logic           hold_full_next;
    logic [DWL-1:0] hold_l;
    logic [DWL-1:0] hold_r;
    logic           accept;
    logic           frame_wrap;
    load_e          load_kind;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (EN),
        .BCLK  (BCLK),
        .TICK  (tick)
    );

    // Each sample sits left-justified in its slot with zero padding below.
    assign slot_l     = SLOT'(hold_l) << (SLOT - DWL);
    assign slot_r     = SLOT'(hold_r) << (SLOT - DWL);
    assign frame_word = {slot_l, slot_r};

    assign accept       = DIN_VLD && DIN_RDY;
    assign frame_wrap   = (bit_cnt == BIT_LAST);
    assign bit_cnt_next = frame_wrap ? '0 : (bit_cnt + BW'(1));

    // Classify the frame boundary using the holding state from before the edge.
    always_comb begin
        load_kind = LOAD_NONE;
        if (tick && frame_wrap) begin
            load_kind = hold_full ? LOAD_SAMPLE : LOAD_UNDERRUN;
        end
    end

    // Holding occupancy: disable clears it, accept fills it, a sample load drains it.
    always_comb begin
        hold_full_next = hold_full;
        if (!EN) begin
            hold_full_next = 1'b0;
        end else if (accept) begin
            hold_full_next = 1'b1;
        end else if (load_kind == LOAD_SAMPLE) begin
            hold_full_next = 1'b0;
        end
    end

    // Holding register and the registered ready flag derived from its next state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            DIN_RDY   <= 1'b0;
        end else begin
            hold_full <= hold_full_next;
            DIN_RDY   <= EN && !hold_full_next;
            if (!EN) begin
                hold_l <= '0;
                hold_r <= '0;
            end else if (accept) begin
                hold_l <= DIN_L;
                hold_r <= DIN_R;
            end
        end
    end

    // Frame sequencing: bit counter, word select, shifter, serial output and strobes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt   <= BIT_LAST;
            fr        <= '0;
            LRCK      <= 1'b0;
            SDATA     <= 1'b0;
            FRAME_STB <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else if (!EN) begin
            bit_cnt   <= BIT_LAST;
            fr        <= '0;
            LRCK      <= 1'b0;
            SDATA     <= 1'b0;
            FRAME_STB <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else begin
            FRAME_STB <= (load_kind != LOAD_NONE);
            UNDERRUN  <= (load_kind == LOAD_UNDERRUN);
            if (tick) begin
                bit_cnt <= bit_cnt_next;
                LRCK    <= (bit_cnt_next >= SLOT_START) ? CH_RIGHT : CH_LEFT;
                SDATA   <= fr[FW-1];
                case (load_kind)
                    LOAD_SAMPLE:   fr <= frame_word;
                    LOAD_UNDERRUN: fr <= '0;
                    default:       fr <= {fr[FW-2:0], 1'b0};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl (DWL=12, SLOT=16, BCLK_DIV=4: 128 CLK per frame).
// SDATA/LRCK/BCLK are sampled mid bit period, with BCLK high, and compared
// against hand-computed slot patterns.
module tb_i2s_tx_ctrl;

    localparam int DWL      = 12;
    localparam int SLOT     = 16;
    localparam int BCLK_DIV = 4;

    logic        CLK;
    logic        RST_N;
    logic        EN;
    logic [11:0] DIN_L;
    logic [11:0] DIN_R;
    logic        DIN_VLD;
    logic        DIN_RDY;
    logic        BCLK;
    logic        LRCK;
    logic        SDATA;
    logic        FRAME_STB;
    logic        UNDERRUN;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic sdLog [0:255];
    logic lrLog [0:255];
    logic bcLog [0:255];
    int   stbQ[$];
    int   urQ[$];
    int   accQ[$];
    logic firstAccRdy;
    logic [11:0] feedL [0:3];
    logic [11:0] feedR [0:3];

    i2s_tx_ctrl #(
        .DWL      (DWL),
        .SLOT     (SLOT),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .EN        (EN),
        .DIN_L     (DIN_L),
        .DIN_R     (DIN_R),
        .DIN_VLD   (DIN_VLD),
        .DIN_RDY   (DIN_RDY),
        .BCLK      (BCLK),
        .LRCK      (LRCK),
        .SDATA     (SDATA),
        .FRAME_STB (FRAME_STB),
        .UNDERRUN  (UNDERRUN)
    );

    // Free-running 100 MHz system clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Global safety net in case a wait ever escapes its bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic en, input logic vld,
                                 input logic [11:0] l, input logic [11:0] r);
        EN      = en;
        DIN_VLD = vld;
        DIN_L   = l;
        DIN_R   = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for FRAME_STB; returns on the negedge where it is seen.
    task automatic waitFrameStb(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge CLK);
            if (FRAME_STB) found = 1'b1;
        end
        checkOutput({tag, "_stbSeen"}, 32'(found), 32'd1);
    endtask

    // Records nPeriods bit periods starting at the current FRAME_STB cycle.
    // With nFeed > 0 it offers feedL/feedR pairs back to back on VLD/RDY.
    task automatic runCapture(input int nPeriods, input int nFeed);
        int   feedIdx;
        logic rdyPrev;
        stbQ.delete();
        urQ.delete();
        accQ.delete();
        firstAccRdy = 1'b1;
        feedIdx     = 0;
        if (nFeed > 0) applyStimulus(1'b1, 1'b1, feedL[0], feedR[0]);
        rdyPrev = DIN_RDY;
        for (int c = 0; c < 4 * nPeriods; c++) begin
            if (c > 0) begin
                @(negedge CLK);
                if (DIN_VLD && rdyPrev) begin
                    accQ.push_back(c);
                    if (accQ.size() == 1) firstAccRdy = DIN_RDY;
                    feedIdx++;
                    if (feedIdx < nFeed) applyStimulus(1'b1, 1'b1, feedL[feedIdx], feedR[feedIdx]);
                    else DIN_VLD = 1'b0;
                end
            end
            if (FRAME_STB) stbQ.push_back(c);
            if (UNDERRUN) urQ.push_back(c);
            if (c % 4 == 2) begin
                sdLog[c / 4] = SDATA;
                lrLog[c / 4] = LRCK;
                bcLog[c / 4] = BCLK;
            end
            rdyPrev = DIN_RDY;
        end
    endtask

    function automatic logic [15:0] slotBits(input int start);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15 - i] = sdLog[start + i];
        return r;
    endfunction

    function automatic logic [31:0] lrVec(input int start);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31 - i] = lrLog[start + i];
        return r;
    endfunction

    function automatic logic [31:0] bcVec(input int start);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31 - i] = bcLog[start + i];
        return r;
    endfunction

    function automatic int onesIn(input int from, input int upto);
        int n;
        n = 0;
        for (int i = from; i <= upto; i++) if (sdLog[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int qAt(input int q[$], input int idx);
        return (q.size() > idx) ? q[idx] : -1;
    endfunction

    function automatic logic [31:0] outVec();
        return {26'b0, DIN_RDY, BCLK, LRCK, SDATA, FRAME_STB, UNDERRUN};
    endfunction

    initial begin
        // Reset held with EN and VLD already asserted.
        RST_N = 1'b0;
        applyStimulus(1'b1, 1'b1, 12'hA5C, 12'h3F1);
        repeat (3) @(negedge CLK);
        checkOutput("t1_resetOutputs", outVec(), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("t1_rdyAfterRelease", 32'(DIN_RDY), 32'd1);
        @(negedge CLK);
        checkOutput("t1_rdyAfterAccept", 32'(DIN_RDY), 32'd0);
        applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);

        // First frame carries A5C/3F1, then four underrun frames.
        waitFrameStb("t2");
        checkOutput("t2_noUnderrun", 32'(UNDERRUN), 32'd0);
        runCapture(129, 0);
        checkOutput("t2_period0", 32'(sdLog[0]), 32'd0);
        checkOutput("t2_leftSlot", 32'(slotBits(1)), 32'h0000A5C0);
        checkOutput("t2_rightSlot", 32'(slotBits(17)), 32'h00003F10);
        checkOutput("t2_lrck", lrVec(0), 32'h0000FFFF);
        checkOutput("t2_bclkHigh", bcVec(0), 32'hFFFFFFFF);
        checkOutput("t3_stbCount", 32'(stbQ.size()), 32'd5);
        for (int f = 0; f < 5; f++) checkOutput("t3_stbCycle", 32'(qAt(stbQ, f)), 32'(f * 128));
        checkOutput("t3_urCount", 32'(urQ.size()), 32'd4);
        for (int f = 0; f < 4; f++) checkOutput("t3_urCycle", 32'(qAt(urQ, f)), 32'((f + 1) * 128));
        checkOutput("t3_sdataQuiet", 32'(onesIn(32, 128)), 32'd0);

        // Three pairs offered back to back with VLD held high.
        feedL[0] = 12'h123; feedR[0] = 12'hFED;
        feedL[1] = 12'h7A0; feedR[1] = 12'h05F;
        feedL[2] = 12'hC3C; feedR[2] = 12'h999;
        waitFrameStb("t4");
        runCapture(129, 3);
        checkOutput("t4_rdyFalls", 32'(firstAccRdy), 32'd0);
        checkOutput("t4_accCount", 32'(accQ.size()), 32'd3);
        for (int i = 0; i < 3; i++) checkOutput("t4_accCycle", 32'(qAt(accQ, i)), 32'(i * 128 + 1));
        checkOutput("t4_stbCount", 32'(stbQ.size()), 32'd5);
        checkOutput("t4_urCount", 32'(urQ.size()), 32'd2);
        checkOutput("t4_urFirst", 32'(qAt(urQ, 0)), 32'd0);
        checkOutput("t4_urLast", 32'(qAt(urQ, 1)), 32'd512);
        for (int f = 1; f <= 3; f++) begin
            checkOutput("t4_leftSlot", 32'(slotBits(32 * f + 1)), 32'({feedL[f - 1], 4'h0}));
            checkOutput("t4_rightSlot", 32'(slotBits(32 * f + 17)), 32'({feedR[f - 1], 4'h0}));
        end

        // Abort mid-frame at bit_cnt 20 with a pair waiting in holding.
        waitFrameStb("t5a");
        applyStimulus(1'b1, 1'b1, 12'hFFF, 12'hFFF);
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 12'hFFF, 12'hFFF);
        waitFrameStb("t5b");
        applyStimulus(1'b1, 1'b1, 12'hFFF, 12'hFFF);
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);
        repeat (80) @(negedge CLK);
        checkOutput("t5_beforeDrop", 32'({LRCK, SDATA, DIN_RDY}), 32'b110);
        applyStimulus(1'b0, 1'b0, 12'h000, 12'h000);
        @(negedge CLK);
        checkOutput("t5_dropOutputs", outVec(), 32'd0);
        repeat (5) @(negedge CLK);
        checkOutput("t5_idleOutputs", outVec(), 32'd0);
        applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);
        waitFrameStb("t5c");
        checkOutput("t5_reenableLoad", 32'({UNDERRUN, LRCK, SDATA}), 32'b100);

        // Full-scale negative left and positive right after re-enable.
        feedL[0] = 12'h800; feedR[0] = 12'h7FF;
        runCapture(65, 1);
        checkOutput("t5_frameSilent", 32'(onesIn(0, 32)), 32'd0);
        checkOutput("t5_lrck", lrVec(0), 32'h0000FFFF);
        checkOutput("t6_accCycle", 32'(qAt(accQ, 0)), 32'd1);
        checkOutput("t6_leftSlot", 32'(slotBits(33)), 32'h00008000);
        checkOutput("t6_rightSlot", 32'(slotBits(49)), 32'h00007FF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
